// File: rtl/instruction_mem_loader_if.sv
// Loader bus: word handshake and session control in, nibble write port and status out.
interface instruction_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  baseAddress;
  logic [COUNT_WIDTH-1:0] wordCount;
  logic                   wordValid;
  logic [31:0]            wordData;
  logic                   wordReady;
  logic                   memWriteEnable;
  logic [ADDR_WIDTH-1:0]  memWriteAddress;
  logic [3:0]             memWriteData;
  logic                   busy;
  logic                   done;
  logic                   overflowError;

  modport master (
    output start, baseAddress, wordCount, wordValid, wordData,
    input  wordReady, memWriteEnable, memWriteAddress, memWriteData,
           busy, done, overflowError
  );

  modport slave (
    input  start, baseAddress, wordCount, wordValid, wordData,
    output wordReady, memWriteEnable, memWriteAddress, memWriteData,
           busy, done, overflowError
  );
endinterface

// File: rtl/instruction_mem_loader.sv
// Program loader: accepts 32-bit words and writes them into 4-bit instruction
// memory as eight little-endian nibble writes at consecutive wrapping addresses.
module instruction_mem_loader #(
  parameter int unsigned MEM_DEPTH        = 1024,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned NIBBLES_PER_WORD = 8,
  parameter int unsigned COUNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_mem_loader_if.slave   bus
);

  localparam int unsigned NIB_W = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [NIB_W-1:0]       nib_q, nib_d;
  logic [31:0]            word_q, word_d;
  logic                   ovf_q, ovf_d;
  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state and next-output logic; status flops mirror the state being entered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    nib_d   = nib_q;
    word_d  = word_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ptr_d   = bus.baseAddress;
          rem_d   = bus.wordCount;
          ovf_d   = 1'b0;
          nib_d   = '0;
          state_d = (bus.wordCount != '0) ? WAIT_WORD : DONE;
        end
      end
      WAIT_WORD: begin
        if (bus.wordValid && ready_q) begin
          word_d  = bus.wordData;
          nib_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Shift the next nibble into the low bits for the following write.
        word_d = word_q >> 4;
        if (ptr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          ptr_d = '0;
          ovf_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
        if (nib_q == NIB_W'(NIBBLES_PER_WORD - 1)) begin
          nib_d   = '0;
          rem_d   = rem_q - COUNT_WIDTH'(1);
          state_d = (rem_q == COUNT_WIDTH'(1)) ? DONE : WAIT_WORD;
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == WAIT_WORD);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      nib_q   <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      nib_q   <= nib_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.wordReady       = ready_q;
  assign bus.memWriteEnable  = we_q;
  assign bus.memWriteAddress = ptr_q;
  assign bus.memWriteData    = word_q[3:0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.overflowError   = ovf_q;

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Directed bench for instruction_mem_loader: nibble write order, handshake timing,
// wrap flag, reset abandonment and ignored starts.
module tb_instruction_mem_loader;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_mem_loader_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  instruction_mem_loader #(
    .MEM_DEPTH(1024), .ADDR_WIDTH(AW), .NIBBLES_PER_WORD(8), .COUNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [13:0] wq[$];
  int done_cnt = 0;
  int both_hi  = 0;

  // Records every write as {address, nibble} and watches the done pulse.
  always @(negedge clk) begin
    if (bus.memWriteEnable) wq.push_back({bus.memWriteAddress, bus.memWriteData});
    if (bus.done) done_cnt++;
    if (bus.memWriteEnable && bus.wordReady) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.wordReady, bus.memWriteEnable, bus.busy, bus.done,
                bus.overflowError, bus.memWriteAddress, bus.memWriteData});
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_session(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
    bus.start = 1'b1; bus.baseAddress = base; bus.wordCount = cnt;
    step();
    bus.start = 1'b0;
  endtask

  // Returns at the negedge of the first nibble write of the accepted word.
  task automatic send_word(input string tag, input logic [31:0] w, input int gap);
    bit sent = 1'b0;
    bus.wordValid = 1'b0;
    step(gap);
    bus.wordValid = 1'b1;
    bus.wordData  = w;
    for (int i = 0; i < 40 && !sent; i++) begin
      if (bus.wordReady) sent = 1'b1;
      step();
    end
    bus.wordValid = 1'b0;
    check({tag, "_accepted"}, 32'(sent), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else step();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_word(input string tag, input int qidx, input int addr0, input logic [31:0] w);
    logic [13:0] exp;
    for (int k = 0; k < 8; k++) begin
      exp = {AW'(addr0 + k), w[4*k +: 4]};
      if (qidx + k < wq.size()) check(tag, 32'(wq[qidx + k]), 32'(exp));
    end
  endtask

  task automatic run_s2(input string tag);
    logic [13:0] s2_exp[8];
    s2_exp = '{{10'h010, 4'h3}, {10'h011, 4'hD}, {10'h012, 4'h2}, {10'h013, 4'hC},
               {10'h014, 4'h1}, {10'h015, 4'hB}, {10'h016, 4'h0}, {10'h017, 4'hA}};
    wq.delete();
    start_session(10'h010, 8'd1);
    check({tag, "_ready"}, 32'(bus.wordReady), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    send_word(tag, 32'hA0B1C2D3, 0);
    check({tag, "_we_first"}, 32'(bus.memWriteEnable), 32'd1);
    check({tag, "_ready_in_write"}, 32'(bus.wordReady), 32'd0);
    step(8);
    check({tag, "_done_t9"}, 32'(bus.done), 32'd1);
    check({tag, "_we_at_done"}, 32'(bus.memWriteEnable), 32'd0);
    step();
    check({tag, "_idle_after"}, 32'({bus.busy, bus.done}), 32'd0);
    step();
    check({tag, "_nwrites"}, 32'(wq.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < wq.size()) check({tag, "_wr"}, 32'(wq[k]), 32'(s2_exp[k]));
  endtask

  initial begin
    int d0;
    logic [31:0] s3_words[3];
    int s3_gaps[3];
    s3_words = '{32'h76543210, 32'hFEDCBA98, 32'h0F1E2D3C};
    s3_gaps  = '{0, 3, 1};

    // Reset with wordValid held high
    bus.start = 1'b0; bus.baseAddress = '0; bus.wordCount = '0;
    bus.wordValid = 1'b1; bus.wordData = 32'hDEADBEEF;
    reset = 1'b1;
    step(2);
    check("rst_outs", outs(), 32'd0);
    reset = 1'b0;
    step(2);
    check("idle_valid_ignored", outs(), 32'd0);
    check("idle_no_writes", 32'(wq.size()), 32'd0);
    bus.wordValid = 1'b0;

    run_s2("s2");

    // Three words with gaps
    d0 = done_cnt;
    wq.delete();
    start_session(10'h000, 8'd3);
    for (int i = 0; i < 3; i++) send_word("s3", s3_words[i], s3_gaps[i]);
    wait_done("s3");
    step(2);
    check("s3_done_once", 32'(done_cnt - d0), 32'd1);
    check("s3_nwrites", 32'(wq.size()), 32'd24);
    for (int i = 0; i < 3; i++) check_word("s3_wr", i * 8, i * 8, s3_words[i]);

    // Address wrap sets the sticky flag
    wq.delete();
    start_session(10'h3FC, 8'd1);
    check("s4_ovf_start", 32'(bus.overflowError), 32'd0);
    send_word("s4", 32'h12345678, 0);
    step(3);
    check("s4_addr_3ff", 32'(bus.memWriteAddress), 32'h3FF);
    check("s4_ovf_before_wrap", 32'(bus.overflowError), 32'd0);
    step();
    check("s4_addr_000", 32'(bus.memWriteAddress), 32'h000);
    check("s4_ovf_after_wrap", 32'(bus.overflowError), 32'd1);
    wait_done("s4");
    step(2);
    check("s4_ovf_held", 32'(bus.overflowError), 32'd1);
    check("s4_nwrites", 32'(wq.size()), 32'd8);
    check_word("s4_wr", 0, 'h3FC, 32'h12345678);

    // Reset mid-word; new start also clears the flag
    wq.delete();
    start_session(10'h020, 8'd2);
    check("s4_ovf_cleared", 32'(bus.overflowError), 32'd0);
    send_word("s5", 32'hCAFEF00D, 0);
    step(2);
    check("s5_third_addr", 32'(bus.memWriteAddress), 32'h022);
    reset = 1'b1;
    step();
    check("s5_rst_outs", outs(), 32'd0);
    reset = 1'b0;
    step();
    check("s5_partial_writes", 32'(wq.size()), 32'd3);
    run_s2("s5_again");

    // Zero-count session, then start pulsed during WRITE
    d0 = done_cnt;
    wq.delete();
    start_session(10'h055, 8'd0);
    check("s6_done_now", 32'(bus.done), 32'd1);
    check("s6_busy_now", 32'(bus.busy), 32'd1);
    check("s6_no_we", 32'(bus.memWriteEnable), 32'd0);
    step();
    check("s6_idle", 32'({bus.busy, bus.done}), 32'd0);
    step(2);
    check("s6_no_writes", 32'(wq.size()), 32'd0);
    start_session(10'h100, 8'd1);
    send_word("s6", 32'h89ABCDEF, 0);
    step(2);
    bus.start = 1'b1; bus.baseAddress = 10'h200; bus.wordCount = 8'd5;
    step();
    bus.start = 1'b0;
    wait_done("s6");
    step(3);
    check("s6_ignored_start", 32'({bus.busy, bus.wordReady}), 32'd0);
    check("s6_nwrites", 32'(wq.size()), 32'd8);
    check_word("s6_wr", 0, 'h100, 32'h89ABCDEF);
    check("s6_done_count", 32'(done_cnt - d0), 32'd2);

    check("ready_never_in_write", 32'(both_hi), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
